// File: rtl/fphub_operand_pairer.sv
// Groups a stream of FPHUB words into (X, Y) operand pairs and buffers them for the adder core.
// Define FPHUB_PAIR_SWAP_EN to store each pair with the larger magnitude first.
module fphub_operand_pairer #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [E+M:0]         in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [E+M:0]         out_X,
  output logic [E+M:0]         out_Y,
  output logic                 out_odd,
  output logic                 out_swapped,
  output logic [$clog2(DEPTH):0] count
);

  localparam int W  = E + M + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    S_X,
    S_Y
  } state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    x_hold_reg, x_hold_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [W-1:0]    fifo_x_reg   [DEPTH];
  logic [W-1:0]    fifo_y_reg   [DEPTH];
  logic            fifo_odd_reg [DEPTH];
  logic            fifo_sw_reg  [DEPTH];

  logic            in_xfer, out_xfer;
  logic            push;
  logic [W-1:0]    push_x, push_y;
  logic            push_odd;
  logic            do_swap;
  logic [W-1:0]    store_x, store_y;

  // Readiness depends only on registered occupancy, so a pop frees space one cycle later.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_next  = state_reg;
    x_hold_next = x_hold_reg;
    push        = 1'b0;
    push_x      = in_data;
    push_y      = '0;
    push_odd    = 1'b0;
    case (state_reg)
      S_X: begin
        if (in_xfer) begin
          if (in_last) begin
            // Zero pad is the HUB zero, which the adder resolves to Z = X.
            push     = 1'b1;
            push_odd = 1'b1;
          end else begin
            x_hold_next = in_data;
            state_next  = S_Y;
          end
        end
      end
      S_Y: begin
        if (in_xfer) begin
          push       = 1'b1;
          push_x     = x_hold_reg;
          push_y     = {in_data[W-1] ^ in_sub, in_data[W-2:0]};
          state_next = S_X;
        end
      end
      default: state_next = S_X;
    endcase
  end

`ifdef FPHUB_PAIR_SWAP_EN
  // Magnitude-only compare; each sign stays with its own operand.
  assign do_swap = !push_odd && (push_y[W-2:0] > push_x[W-2:0]);
`else
  assign do_swap = 1'b0;
`endif

  assign store_x = do_swap ? push_y : push_x;
  assign store_y = do_swap ? push_x : push_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_X;
      x_hold_reg <= '0;
    end else begin
      state_reg  <= state_next;
      x_hold_reg <= x_hold_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (out_xfer) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, out_xfer})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fifo_x_reg[gi]   <= '0;
          fifo_y_reg[gi]   <= '0;
          fifo_odd_reg[gi] <= 1'b0;
          fifo_sw_reg[gi]  <= 1'b0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          fifo_x_reg[gi]   <= store_x;
          fifo_y_reg[gi]   <= store_y;
          fifo_odd_reg[gi] <= push_odd;
          fifo_sw_reg[gi]  <= do_swap;
        end
      end
    end
  endgenerate

  assign out_X       = fifo_x_reg[rd_ptr_reg];
  assign out_Y       = fifo_y_reg[rd_ptr_reg];
  assign out_odd     = fifo_odd_reg[rd_ptr_reg];
  assign out_swapped = fifo_sw_reg[rd_ptr_reg];
  assign count       = count_reg;

endmodule

// File: tb/tb_fphub_operand_pairer.sv
// Bench for fphub_operand_pairer: queue-based pairing model checked every cycle plus literal checks.
module tb_fphub_operand_pairer;

  localparam int M     = 23;
  localparam int E     = 8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_X, out_Y;
  logic        out_odd, out_swapped;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        odd;
    logic        sw;
  } pair_t;

  pair_t       mq[$];
  logic        have_x = 1'b0;
  logic [31:0] x_val = '0;

  fphub_operand_pairer #(.M(M), .E(E), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_X(out_X), .out_Y(out_Y), .out_odd(out_odd), .out_swapped(out_swapped),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic pair_t make_pair(input logic [31:0] x, input logic [31:0] y, input logic odd);
    pair_t p;
    p.x = x; p.y = y; p.odd = odd; p.sw = 1'b0;
`ifdef FPHUB_PAIR_SWAP_EN
    if (!odd && (y[30:0] > x[30:0])) begin
      p.x = y; p.y = x; p.sw = 1'b1;
    end
`endif
    return p;
  endfunction

  // Compare at the falling edge, then advance the model with the transfers the next rising edge makes.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      have_x = 1'b0;
      x_val  = '0;
    end else begin
      bit m_ready, m_pop, m_in;
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      if (mq.size() != 0) begin
        chk("head_X", out_X, mq[0].x);
        chk("head_Y", out_Y, mq[0].y);
        chk("head_odd", 32'(out_odd), 32'(mq[0].odd));
        chk("head_swapped", 32'(out_swapped), 32'(mq[0].sw));
      end
      m_ready = (mq.size() != DEPTH);
      m_pop   = (mq.size() != 0) && out_ready;
      m_in    = in_valid && m_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_in) begin
        if (!have_x) begin
          if (in_last) mq.push_back(make_pair(in_data, 32'h0, 1'b1));
          else begin
            have_x = 1'b1;
            x_val  = in_data;
          end
        end else begin
          mq.push_back(make_pair(x_val, in_data ^ {in_sub, 31'h0}, 1'b0));
          have_x = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] d, input logic sub, input logic last);
    int n = 0;
    in_data = d; in_sub = sub; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accepted", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_X", out_X, 32'h0);
    chk("rst_out_Y", out_Y, 32'h0);
    chk("rst_odd_sw", {30'h0, out_odd, out_swapped}, 32'h0);
    idle(2);
    rst = 1'b0;

    // Basic pair
    out_ready = 1'b1;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    $display("pair 3F800000,40000000 -> X=%h Y=%h sw=%0d", out_X, out_Y, out_swapped);
    chk("t1_valid", 32'(out_valid), 32'd1);
`ifdef FPHUB_PAIR_SWAP_EN
    chk("t1_X", out_X, 32'h40000000);
    chk("t1_Y", out_Y, 32'h3F800000);
    chk("t1_sw", 32'(out_swapped), 32'd1);
`else
    chk("t1_X", out_X, 32'h3F800000);
    chk("t1_Y", out_Y, 32'h40000000);
    chk("t1_sw", 32'(out_swapped), 32'd0);
`endif

    // Subtraction flips Y's sign
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b1, 1'b0);
    $display("pair sub 3F800000,40000000 -> X=%h Y=%h sw=%0d", out_X, out_Y, out_swapped);
`ifdef FPHUB_PAIR_SWAP_EN
    chk("t2_X", out_X, 32'hC0000000);
    chk("t2_Y", out_Y, 32'h3F800000);
`else
    chk("t2_X", out_X, 32'h3F800000);
    chk("t2_Y", out_Y, 32'hC0000000);
`endif

    // Lone last word gets a zero pad; in_sub ignored on the first word
    send(32'h3F800000, 1'b1, 1'b1);
    $display("odd 3F800000 -> X=%h Y=%h odd=%0d", out_X, out_Y, out_odd);
    chk("t3_X", out_X, 32'h3F800000);
    chk("t3_Y", out_Y, 32'h0);
    chk("t3_odd", 32'(out_odd), 32'd1);
    chk("t3_sw", 32'(out_swapped), 32'd0);
    idle(3);

    // Backpressure with DEPTH=2
    out_ready = 1'b0;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    send(32'h40800000, 1'b0, 1'b0);
    $display("full: count=%0d in_ready=%0d", count, in_ready);
    chk("t4_count_full", 32'(count), 32'd2);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
`ifdef FPHUB_PAIR_SWAP_EN
    chk("t4_head_X", out_X, 32'h40000000);
`else
    chk("t4_head_X", out_X, 32'h3F800000);
`endif
    fork
      send(32'h40A00000, 1'b0, 1'b0);
      begin
        idle(3);
        chk("t4_still_full", 32'(count), 32'd2);
        out_ready = 1'b1;
      end
    join
    send(32'h40C00000, 1'b0, 1'b0);
    idle(6);
    $display("drained: count=%0d", count);
    chk("t4_drained", 32'(count), 32'd0);

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    out_ready = 1'b1;
    send(32'h3F800000, 1'b0, 1'b0);
    $display("push+pop: count=%0d X=%h Y=%h", count, out_X, out_Y);
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_X", out_X, 32'h40400000);
    chk("t5_Y", out_Y, 32'h3F800000);
    idle(3);
    chk("t5_empty", 32'(count), 32'd0);

    // Asynchronous reset mid-pair
    out_ready = 1'b0;
    send(32'h3F800000, 1'b0, 1'b0);
    send(32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    $display("async rst: out_valid=%0d count=%0d in_ready=%0d", out_valid, count, in_ready);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h40800000, 1'b0, 1'b0);
    send(32'h3F800000, 1'b0, 1'b0);
    $display("fresh pair: X=%h Y=%h odd=%0d", out_X, out_Y, out_odd);
    chk("t6_X", out_X, 32'h40800000);
    chk("t6_Y", out_Y, 32'h3F800000);
    chk("t6_odd", 32'(out_odd), 32'd0);
    chk("t6_count1", 32'(count), 32'd1);

    out_ready = 1'b1;
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
